// File: rtl/prog_pkg.sv
// Shared definitions for the ICCM program load/readback paths.
package prog_pkg;

  // Readback engine sequencing states.
  typedef enum logic [2:0] {
    IDLE,
    READ,
    LOAD,
    SEND,
    DONE
  } dump_state_e;

  localparam int UART_DATA_BITS  = 8;
  localparam int BYTES_PER_WORD  = 4;
  // Start bit + data bits + stop bit; also used by uart_rx_prog.
  localparam int UART_FRAME_BITS = UART_DATA_BITS + 2;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 serializer: one start bit, eight data bits LSB first, one stop bit.
// A start request in the final cycle of a stop bit chains the next frame
// with no idle gap.
module uart_tx_byte
  import prog_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [7:0]  byte_i,
  input  logic [15:0] clks_per_bit_i,
  output logic        tx_o,
  output logic        done_o
);

  logic        r_active;
  logic [15:0] r_cnt;
  logic [15:0] r_period;
  logic [3:0]  r_bit_idx;
  logic [7:0]  r_data;

  logic [15:0] w_period_eff;
  logic        w_bit_end;
  logic        w_last_bit;
  logic [2:0]  w_data_sel;

  // A zero period would never end a bit, so it runs as one cycle per bit.
  assign w_period_eff = (clks_per_bit_i == 16'd0) ? 16'd1 : clks_per_bit_i;
  assign w_bit_end    = r_active && (r_cnt == r_period - 16'd1);
  assign w_last_bit   = (r_bit_idx == 4'(UART_FRAME_BITS - 1));
  assign w_data_sel   = 3'(r_bit_idx - 4'd1);
  assign done_o       = w_bit_end && w_last_bit;

  // Bit-period counter and frame position; period and data frozen per frame.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_active  <= 1'b0;
      r_cnt     <= 16'd0;
      r_period  <= 16'd1;
      r_bit_idx <= 4'd0;
      r_data    <= 8'd0;
    end else if (start_i) begin
      r_active  <= 1'b1;
      r_cnt     <= 16'd0;
      r_period  <= w_period_eff;
      r_bit_idx <= 4'd0;
      r_data    <= byte_i;
    end else if (r_active) begin
      if (w_bit_end) begin
        r_cnt <= 16'd0;
        if (w_last_bit) begin
          r_active <= 1'b0;
        end else begin
          r_bit_idx <= r_bit_idx + 4'd1;
        end
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  // Line level: idle high, start low, data bits, stop high.
  always_comb begin
    tx_o = 1'b1;
    if (r_active) begin
      if (r_bit_idx == 4'd0) begin
        tx_o = 1'b0;
      end else if (w_last_bit) begin
        tx_o = 1'b1;
      end else begin
        tx_o = r_data[w_data_sel];
      end
    end
  end

endmodule

// File: rtl/iccm_dump_tx.sv
// ICCM readback: reads words from address 0 upward and sends each as four
// UART bytes, least-significant byte first.
module iccm_dump_tx
  import prog_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = ADDR_W + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              dump_i,
  input  logic [CNT_W-1:0]  num_words_i,
  input  logic [15:0]       clks_per_bit_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [31:0]       rd_data_i,
  output logic              tx_o,
  output logic              busy_o,
  output logic              done_o
);

  dump_state_e r_state;
  dump_state_e w_state_next;

  logic [CNT_W-1:0]  r_count;
  logic [15:0]       r_period;
  logic [ADDR_W-1:0] r_addr;
  // Bytes of the current word not yet handed to the serializer.
  logic [23:0]       r_rest;
  logic [1:0]        r_byte_idx;

  logic       w_tx_start;
  logic [7:0] w_tx_byte;
  logic       w_tx_done;
  logic       w_last_word;
  logic       w_last_byte;

  // Compare against count-1 so a full 2^ADDR_W dump stops at the top address.
  assign w_last_word = (CNT_W'(r_addr) == (r_count - CNT_W'(1)));
  assign w_last_byte = (r_byte_idx == 2'(BYTES_PER_WORD - 1));
  assign rd_addr_o   = r_addr;

  uart_tx_byte u_tx (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .start_i        (w_tx_start),
    .byte_i         (w_tx_byte),
    .clks_per_bit_i (r_period),
    .tx_o           (tx_o),
    .done_o         (w_tx_done)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Latched job parameters, word address and byte shifter.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_count    <= '0;
      r_period   <= 16'd1;
      r_addr     <= '0;
      r_rest     <= '0;
      r_byte_idx <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (dump_i && (num_words_i != '0)) begin
            r_count  <= num_words_i;
            r_period <= clks_per_bit_i;
            r_addr   <= '0;
          end
        end
        LOAD: begin
          r_rest     <= rd_data_i[31:8];
          r_byte_idx <= '0;
        end
        SEND: begin
          if (w_tx_done) begin
            r_rest     <= r_rest >> 8;
            r_byte_idx <= r_byte_idx + 2'd1;
            if (w_last_byte && !w_last_word) begin
              r_addr <= r_addr + ADDR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Next state, SRAM strobe, serializer kick and status outputs.
  always_comb begin
    w_state_next = r_state;
    w_tx_start   = 1'b0;
    w_tx_byte    = r_rest[7:0];
    rd_en_o      = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    case (r_state)
      IDLE: begin
        if (dump_i) begin
          w_state_next = (num_words_i != '0) ? READ : DONE;
        end
      end
      READ: begin
        rd_en_o      = 1'b1;
        busy_o       = 1'b1;
        w_state_next = LOAD;
      end
      LOAD: begin
        busy_o       = 1'b1;
        w_tx_start   = 1'b1;
        w_tx_byte    = rd_data_i[7:0];
        w_state_next = SEND;
      end
      SEND: begin
        busy_o = 1'b1;
        if (w_tx_done) begin
          if (!w_last_byte) begin
            w_tx_start = 1'b1;
          end else if (w_last_word) begin
            w_state_next = DONE;
          end else begin
            w_state_next = READ;
          end
        end
      end
      DONE: begin
        done_o       = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_iccm_dump_tx.sv
// Directed bench for iccm_dump_tx: a default-size instance and an ADDR_W=2
// instance, each with a registered-read memory model and a UART decoder.
module tb_iccm_dump_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;

  logic        dump1 = 1'b0;
  logic [12:0] num1 = '0;
  logic [15:0] cpb1 = '0;
  logic        rd_en1;
  logic [11:0] addr1;
  logic [31:0] rdata1 = '0;
  logic        tx1, busy1, done1;

  logic        dump2 = 1'b0;
  logic [2:0]  num2 = '0;
  logic [15:0] cpb2 = '0;
  logic        rd_en2;
  logic [1:0]  addr2;
  logic [31:0] rdata2 = '0;
  logic        tx2, busy2, done2;

  logic [31:0] mem1 [0:4095];
  logic [31:0] mem2 [0:3];

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int p1 = 4;
  int p2 = 1;
  int ferr1 = 0;
  int ferr2 = 0;

  logic [7:0]  bq1[$];
  logic [7:0]  bq2[$];
  int          sq1[$];
  int          rc1[$];
  logic [11:0] rq1[$];
  logic [1:0]  rq2[$];
  int          dq1[$];
  int          dq2[$];

  iccm_dump_tx dut1 (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .dump_i         (dump1),
    .num_words_i    (num1),
    .clks_per_bit_i (cpb1),
    .rd_en_o        (rd_en1),
    .rd_addr_o      (addr1),
    .rd_data_i      (rdata1),
    .tx_o           (tx1),
    .busy_o         (busy1),
    .done_o         (done1)
  );

  iccm_dump_tx #(.ADDR_W(2)) dut2 (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .dump_i         (dump2),
    .num_words_i    (num2),
    .clks_per_bit_i (cpb2),
    .rd_en_o        (rd_en2),
    .rd_addr_o      (addr2),
    .rd_data_i      (rdata2),
    .tx_o           (tx2),
    .busy_o         (busy2),
    .done_o         (done2)
  );

  // Cycle counter: cycle k is the interval after the k-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Memory models: data valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (rd_en1) rdata1 <= mem1[addr1];
    if (rd_en2) rdata2 <= mem2[addr2];
  end

  // Record read strobes and done pulses with their cycle numbers.
  always @(negedge clk) begin
    if (rd_en1 === 1'b1) begin
      rq1.push_back(addr1);
      rc1.push_back(cyc);
    end
    if (done1 === 1'b1) dq1.push_back(cyc);
    if (rd_en2 === 1'b1) rq2.push_back(addr2);
    if (done2 === 1'b1) dq2.push_back(cyc);
  end

  function automatic logic txv(input bit sel);
    return sel ? tx2 : tx1;
  endfunction

  // Sample mid-bit for each of the ten frame bits; flag bad start/stop.
  task automatic rx_frame(input bit sel, input int p, output logic [7:0] b, output bit bad);
    bad = 1'b0;
    b = 8'h00;
    repeat (p / 2) @(negedge clk);
    if (txv(sel) !== 1'b0) bad = 1'b1;
    for (int i = 0; i < 8; i++) begin
      repeat (p) @(negedge clk);
      b[i] = txv(sel);
    end
    repeat (p) @(negedge clk);
    if (txv(sel) !== 1'b1) bad = 1'b1;
  endtask

  // UART decoder for instance 1.
  always begin : rx1
    logic [7:0] b;
    bit bad;
    int s;
    @(negedge clk);
    if (rst_n === 1'b1 && tx1 === 1'b0) begin
      s = cyc;
      rx_frame(1'b0, p1, b, bad);
      bq1.push_back(b);
      sq1.push_back(s);
      if (bad) ferr1++;
    end
  end

  // UART decoder for instance 2.
  always begin : rx2
    logic [7:0] b;
    bit bad;
    @(negedge clk);
    if (rst_n === 1'b1 && tx2 === 1'b0) begin
      rx_frame(1'b1, p2, b, bad);
      bq2.push_back(b);
      if (bad) ferr2++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    bq1.delete(); sq1.delete(); rc1.delete(); rq1.delete(); dq1.delete();
    bq2.delete(); rq2.delete(); dq2.delete();
    ferr1 = 0;
    ferr2 = 0;
  endtask

  task automatic start1(input int nw, input int cpb, output int n);
    @(negedge clk);
    num1 = 13'(nw);
    cpb1 = 16'(cpb);
    dump1 = 1'b1;
    n = cyc;
    @(negedge clk);
    dump1 = 1'b0;
  endtask

  task automatic start2(input int nw, input int cpb, output int n);
    @(negedge clk);
    num2 = 3'(nw);
    cpb2 = 16'(cpb);
    dump2 = 1'b1;
    n = cyc;
    @(negedge clk);
    dump2 = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (((sel ? dq2.size() : dq1.size()) < target) && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    chk(tag, sel ? dq2.size() : dq1.size(), target);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    logic [7:0] exp_b [0:11];

    // ---------------- reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx1, 1);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_rd_en", rd_en1, 0);
    chk("rst_addr", addr1, 0);
    chk("rst_tx2", tx2, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ---------------- P=4, one word
    mem1[0] = 32'h12345678;
    clear_q();
    p1 = 4;
    start1(1, 4, n);
    chk("t1_busy_n1", busy1, 1);
    chk("t1_rd_en_n1", rd_en1, 1);
    wait_done(1'b0, 1, 400, "t1_done_seen");
    chk("t1_done_cyc", dq1[0], n + 3 + 160);
    chk("t1_nbytes", bq1.size(), 4);
    chk("t1_b0", bq1[0], 8'h78);
    chk("t1_b1", bq1[1], 8'h56);
    chk("t1_b2", bq1[2], 8'h34);
    chk("t1_b3", bq1[3], 8'h12);
    chk("t1_start_cyc", sq1[0], n + 3);
    chk("t1_nreads", rq1.size(), 1);
    chk("t1_rd_addr", rq1[0], 0);
    chk("t1_rd_cyc", rc1[0], n + 1);
    chk("t1_frame_err", ferr1, 0);
    $display("txn t1 P=4 W=1 bytes=%0d done_cyc=%0d", bq1.size(), dq1[0] - n);

    // ---------------- P=2, three words
    mem1[0] = 32'hA5A5A5A5;
    mem1[1] = 32'h00000000;
    mem1[2] = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) begin
      exp_b[i] = 8'hA5;
      exp_b[i + 4] = 8'h00;
      exp_b[i + 8] = 8'hFF;
    end
    repeat (3) @(negedge clk);
    clear_q();
    p1 = 2;
    start1(3, 2, n);
    wait_done(1'b0, 1, 600, "t2_done_seen");
    chk("t2_done_cyc", dq1[0], n + 1 + 3 * 82);
    chk("t2_nbytes", bq1.size(), 12);
    for (int i = 0; i < 12; i++) chk($sformatf("t2_b%0d", i), bq1[i], exp_b[i]);
    chk("t2_b2b", sq1[1] - sq1[0], 20);
    chk("t2_gap01", sq1[4] - sq1[3], 22);
    chk("t2_gap12", sq1[8] - sq1[7], 22);
    chk("t2_nreads", rq1.size(), 3);
    for (int i = 0; i < 3; i++) chk($sformatf("t2_addr%0d", i), rq1[i], i);
    chk("t2_frame_err", ferr1, 0);
    $display("txn t2 P=2 W=3 bytes=%0d done_cyc=%0d", bq1.size(), dq1[0] - n);

    // ---------------- zero words
    repeat (3) @(negedge clk);
    clear_q();
    start1(0, 4, n);
    repeat (20) @(negedge clk);
    chk("t3_ndone", dq1.size(), 1);
    chk("t3_done_cyc", dq1[0], n + 1);
    chk("t3_nbytes", bq1.size(), 0);
    chk("t3_nreads", rq1.size(), 0);
    chk("t3_tx_idle", tx1, 1);
    $display("txn t3 W=0 done_cyc=%0d", dq1[0] - n);

    // ---------------- clks_per_bit = 0 runs at one cycle per bit
    mem1[0] = 32'h3C96A50F;
    clear_q();
    p1 = 1;
    start1(1, 0, n);
    wait_done(1'b0, 1, 200, "t4_done_seen");
    chk("t4_done_cyc", dq1[0], n + 1 + 42);
    chk("t4_b0", bq1[0], 8'h0F);
    chk("t4_b3", bq1[3], 8'h3C);
    chk("t4_bit_period", sq1[1] - sq1[0], 10);
    $display("txn t4 P=0 bytes=%0d done_cyc=%0d", bq1.size(), dq1[0] - n);

    // ---------------- inputs changed mid-dump have no effect
    repeat (3) @(negedge clk);
    clear_q();
    p1 = 3;
    start1(1, 3, n);
    cpb1 = 16'd9;
    num1 = 13'd7;
    wait_done(1'b0, 1, 300, "t5_done_seen");
    chk("t5_done_cyc", dq1[0], n + 1 + 122);
    chk("t5_nbytes", bq1.size(), 4);
    chk("t5_b1", bq1[1], 8'hA5);
    chk("t5_span", sq1[3] - sq1[0], 90);
    chk("t5_nreads", rq1.size(), 1);
    $display("txn t5 P=3 change-mid bytes=%0d done_cyc=%0d", bq1.size(), dq1[0] - n);

    // ---------------- dump re-asserted while busy
    mem1[0] = 32'hA5A5A5A5;
    repeat (3) @(negedge clk);
    clear_q();
    p1 = 2;
    start1(2, 2, n);
    repeat (30) @(negedge clk);
    dump1 = 1'b1;
    @(negedge clk);
    dump1 = 1'b0;
    wait_done(1'b0, 1, 400, "t6_done_seen");
    repeat (40) @(negedge clk);
    chk("t6_done_cyc", dq1[0], n + 1 + 2 * 82);
    chk("t6_ndone", dq1.size(), 1);
    chk("t6_nbytes", bq1.size(), 8);
    chk("t6_nreads", rq1.size(), 2);
    $display("txn t6 retrigger bytes=%0d reads=%0d", bq1.size(), rq1.size());

    // ---------------- reset during byte 2 of word 0, P=8
    mem1[0] = 32'h12345678;
    clear_q();
    p1 = 8;
    start1(1, 8, n);
    for (int k = 0; k < 400 && cyc < n + 168; k++) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t7_tx_after_rst", tx1, 1);
    chk("t7_busy_after_rst", busy1, 0);
    chk("t7_done_after_rst", done1, 0);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("t7_no_done", dq1.size(), 0);
    clear_q();
    p1 = 2;
    start1(1, 2, n);
    chk("t7_restart_addr", addr1, 0);
    chk("t7_restart_rd_en", rd_en1, 1);
    wait_done(1'b0, 1, 200, "t7_done_seen");
    chk("t7_done_cyc", dq1[0], n + 1 + 82);
    chk("t7_b0", bq1[0], 8'h78);
    chk("t7_b3", bq1[3], 8'h12);
    chk("t7_rd_addr", rq1[0], 0);
    $display("txn t7 reset-mid restart bytes=%0d", bq1.size());

    // ---------------- ADDR_W=2 full-range dump
    mem2[0] = 32'h11223344;
    mem2[1] = 32'h55667788;
    mem2[2] = 32'h99AABBCC;
    mem2[3] = 32'hDDEEFF00;
    repeat (3) @(negedge clk);
    clear_q();
    p2 = 1;
    start2(4, 1, n);
    wait_done(1'b1, 1, 400, "t8_done_seen");
    chk("t8_done_cyc", dq2[0], n + 1 + 4 * 42);
    repeat (50) @(negedge clk);
    chk("t8_nreads", rq2.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t8_addr%0d", i), rq2[i], i);
    chk("t8_nbytes", bq2.size(), 16);
    chk("t8_first", bq2[0], 8'h44);
    chk("t8_last", bq2[15], 8'hDD);
    chk("t8_ndone", dq2.size(), 1);
    chk("t8_frame_err", ferr2, 0);
    $display("txn t8 ADDR_W=2 W=4 bytes=%0d reads=%0d", bq2.size(), rq2.size());

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
